// File: rtl/output_vc_buffer_if.sv
// Arbitrator-to-output-buffer write ports and the link send/ready handshake of one ring-router output.
// The master drives the writes, polarity and ready. The slave is the output buffer itself.
interface output_vc_buffer_if #(
  parameter int DATA_W = 64
);
  logic              polarity;
  logic              even_wr_en;
  logic [DATA_W-1:0] even_wr_data;
  logic              odd_wr_en;
  logic [DATA_W-1:0] odd_wr_data;
  logic              even_empty;
  logic              odd_empty;
  logic              out_send;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              vc_err;

  modport master (
    output polarity, even_wr_en, even_wr_data, odd_wr_en, odd_wr_data, out_ready,
    input  even_empty, odd_empty, out_send, out_data, vc_err
  );

  modport slave (
    input  polarity, even_wr_en, even_wr_data, odd_wr_en, odd_wr_data, out_ready,
    output even_empty, odd_empty, out_send, out_data, vc_err
  );
endinterface

// File: rtl/output_vc_buffer.sv
// Ring-router output buffer: one flit slot per VC, filled in its arbitration phase and drained in its link phase.
// Optional OUTBUF_STATS_EN adds the tx_count (wrapping) and stall_count (saturating) counters.
module output_vc_buffer #(
  parameter int DATA_W = 64,
  parameter int VC_BIT = 63
) (
  input  logic         clk,
  input  logic         reset,
  output_vc_buffer_if.slave bus
`ifdef OUTBUF_STATS_EN
  ,
  output logic [15:0]  tx_count,
  output logic [15:0]  stall_count
`endif
);
  logic              full_even, full_odd;
  logic [DATA_W-1:0] data_even, data_odd;
  logic              vc_err_q;
  logic              wr_even, wr_odd;
  logic              full_l;
  logic [DATA_W-1:0] data_l;
  logic              send;

  // polarity=0: even VC is being written, odd VC is on the link. polarity=1: the reverse.
  assign wr_even = ~bus.polarity & bus.even_wr_en & ~full_even;
  assign wr_odd  =  bus.polarity & bus.odd_wr_en  & ~full_odd;
  assign full_l  = bus.polarity ? full_even : full_odd;
  assign data_l  = bus.polarity ? data_even : data_odd;
  assign send    = full_l & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_even <= 1'b0;
      full_odd  <= 1'b0;
      data_even <= '0;
      data_odd  <= '0;
      vc_err_q  <= 1'b0;
    end else begin
      if (wr_even) begin
        full_even <= 1'b1;
        data_even <= bus.even_wr_data;
      end else if (send && bus.polarity) begin
        full_even <= 1'b0;
      end
      if (wr_odd) begin
        full_odd <= 1'b1;
        data_odd <= bus.odd_wr_data;
      end else if (send && !bus.polarity) begin
        full_odd <= 1'b0;
      end
      if ((wr_even && bus.even_wr_data[VC_BIT]) || (wr_odd && !bus.odd_wr_data[VC_BIT]))
        vc_err_q <= 1'b1;
    end
  end

  assign bus.even_empty = ~full_even;
  assign bus.odd_empty  = ~full_odd;
  assign bus.out_send   = send;
  assign bus.out_data   = send ? data_l : '0;
  assign bus.vc_err     = vc_err_q;

`ifdef OUTBUF_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count    <= '0;
      stall_count <= '0;
    end else begin
      if (send)
        tx_count <= tx_count + 16'd1;
      if (full_l && !bus.out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_output_vc_buffer.sv
// Self-checking bench for output_vc_buffer: a fixed vector table, hand-written corner sequences,
// and random traffic compared against a per-VC array model.
module tb_output_vc_buffer;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_vc_buffer_if #(.DATA_W(DATA_W)) bus ();
`ifdef OUTBUF_STATS_EN
  logic [15:0] tx_count, stall_count;
`endif

  output_vc_buffer #(.DATA_W(DATA_W), .VC_BIT(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef OUTBUF_STATS_EN
    ,
    .tx_count    (tx_count),
    .stall_count (stall_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: slot v holds a flit of VC v (0 = even, 1 = odd).
  logic        m_full [2];
  logic [63:0] m_data [2];
  logic        m_err;
  int          m_tx, m_stall;

  typedef struct {
    logic        pol;
    logic        ewe;
    logic [63:0] ewd;
    logic        owe;
    logic [63:0] owd;
    logic        rdy;
    logic        send;
    logic [63:0] data;
    logic        ee;
    logic        oe;
    logic        err;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(logic pol, logic ewe, logic [63:0] ewd, logic owe, logic [63:0] owd,
                              logic rdy, logic send, logic [63:0] data, logic ee, logic oe, logic err);
    vec_t v;
    v.pol = pol; v.ewe = ewe; v.ewd = ewd; v.owe = owe; v.owd = owd; v.rdy = rdy;
    v.send = send; v.data = data; v.ee = ee; v.oe = oe; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int v = 0; v < 2; v++) begin
      m_full[v] = 1'b0;
      m_data[v] = '0;
    end
    m_err   = 1'b0;
    m_tx    = 0;
    m_stall = 0;
  endfunction

  // Applies one clock edge to the model from the inputs currently on the bus.
  function automatic void model_edge();
    int a, l;
    logic we;
    logic [63:0] wd;
    a  = bus.polarity ? 1 : 0;
    l  = 1 - a;
    we = a ? bus.odd_wr_en : bus.even_wr_en;
    wd = a ? bus.odd_wr_data : bus.even_wr_data;
    if (m_full[l] && bus.out_ready) begin
      m_full[l] = 1'b0;
      m_tx = (m_tx + 1) % 65536;
    end else if (m_full[l] && m_stall < 65535) begin
      m_stall++;
    end
    if (we && !m_full[a]) begin
      m_full[a] = 1'b1;
      m_data[a] = wd;
      if (int'(wd[63]) != a) m_err = 1'b1;
    end
  endfunction

  task automatic check_stats();
`ifdef OUTBUF_STATS_EN
    check("tx_count", 64'(tx_count), 64'(m_tx));
    check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
  endtask

  task automatic check_model();
    int l;
    logic s;
    l = bus.polarity ? 0 : 1;
    s = m_full[l] && bus.out_ready;
    check("out_send", 64'(bus.out_send), 64'(s));
    check("out_data", bus.out_data, s ? m_data[l] : 64'h0);
    check("even_empty", 64'(bus.even_empty), 64'(!m_full[0]));
    check("odd_empty", 64'(bus.odd_empty), 64'(!m_full[1]));
    check("vc_err", 64'(bus.vc_err), 64'(m_err));
    check_stats();
  endtask

  task automatic drive(input logic pol, input logic ewe, input logic [63:0] ewd,
                       input logic owe, input logic [63:0] owd, input logic rdy);
    @(negedge clk);
    bus.polarity     = pol;
    bus.even_wr_en   = ewe;
    bus.even_wr_data = ewd;
    bus.odd_wr_en    = owe;
    bus.odd_wr_data  = owd;
    bus.out_ready    = rdy;
    #1;
  endtask

  task automatic cycle(input logic pol, input logic ewe, input logic [63:0] ewd,
                       input logic owe, input logic [63:0] owd, input logic rdy);
    drive(pol, ewe, ewd, owe, owd, rdy);
    check_model();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_out_send", 64'(bus.out_send), 64'h0);
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_even_empty", 64'(bus.even_empty), 64'h1);
    check("rst_odd_empty", 64'(bus.odd_empty), 64'h1);
    check("rst_vc_err", 64'(bus.vc_err), 64'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam logic [63:0] A = 64'h0000_0300_0000_00AA;
  localparam logic [63:0] B = 64'h8000_0000_0000_00B1;
  localparam logic [63:0] C = 64'h0000_0000_0000_00C2;
  localparam logic [63:0] D = 64'h0000_0000_0000_00D3;
  localparam logic [63:0] E = 64'h0000_0000_0000_00E4;
  localparam logic [63:0] F = 64'h8000_0000_0000_00F8;
  localparam logic [63:0] G = 64'h8000_0000_1234_0006;
  localparam logic [63:0] H = 64'h8000_0000_5678_0007;

  initial begin
    int stall0;
    logic pol, ewe, owe, rdy;
    logic [63:0] ewd, owd;

    reset = 1'b1;
    bus.polarity = 1'b0; bus.even_wr_en = 1'b0; bus.odd_wr_en = 1'b0;
    bus.even_wr_data = '0; bus.odd_wr_data = '0; bus.out_ready = 1'b0;
    model_reset();
    #12;
    check("init_even_empty", 64'(bus.even_empty), 64'h1);
    check("init_odd_empty", 64'(bus.odd_empty), 64'h1);
    check("init_out_send", 64'(bus.out_send), 64'h0);
    check("init_vc_err", 64'(bus.vc_err), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    //             pol ewe ewd owe owd rdy | send data ee oe err
    tbl[0]  = mk(0, 1, A, 0, 0, 1,  0, 0, 1, 1, 0);
    tbl[1]  = mk(1, 0, 0, 1, B, 1,  1, A, 0, 1, 0);
    tbl[2]  = mk(0, 1, C, 0, 0, 1,  1, B, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tbl[4]  = mk(1, 1, D, 0, 0, 0,  0, 0, 0, 1, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 1,  1, C, 0, 1, 0);
    tbl[6]  = mk(1, 1, E, 0, 0, 1,  0, 0, 1, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 0);
    tbl[8]  = mk(0, 1, F, 0, 0, 1,  0, 0, 1, 1, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 1,  1, F, 0, 1, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 1,  0, 0, 1, 1, 1);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].pol, tbl[i].ewe, tbl[i].ewd, tbl[i].owe, tbl[i].owd, tbl[i].rdy);
      check($sformatf("tbl%0d_send", i), 64'(bus.out_send), 64'(tbl[i].send));
      check($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].data);
      check($sformatf("tbl%0d_even_empty", i), 64'(bus.even_empty), 64'(tbl[i].ee));
      check($sformatf("tbl%0d_odd_empty", i), 64'(bus.odd_empty), 64'(tbl[i].oe));
      check($sformatf("tbl%0d_vc_err", i), 64'(bus.vc_err), 64'(tbl[i].err));
      check_stats();
      @(posedge clk);
      model_edge();
    end

    // Stall: odd flit held 5 link-phase cycles with ready low, write to full slot dropped.
    do_reset();
    cycle(1, 0, 0, 1, G, 0);
    stall0 = m_stall;
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, H, 0);
    cycle(1, 0, 0, 1, H, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("stall_send", 64'(bus.out_send), 64'h1);
    check("stall_full_write_dropped", bus.out_data, G);
`ifdef OUTBUF_STATS_EN
    check("stall_count_5", 64'(stall_count), 64'(stall0 + 5));
`endif
    check_model();
    @(posedge clk);
    model_edge();
    cycle(0, 0, 0, 0, 0, 1);

    // Asynchronous reset mid-transfer with both slots full and vc_err set.
    cycle(0, 1, F, 0, 0, 0);
    cycle(1, 0, 0, 1, G, 0);
    drive(0, 0, 0, 0, 0, 1);
    check("pre_rst_send", 64'(bus.out_send), 64'h1);
    check("pre_rst_vc_err", 64'(bus.vc_err), 64'h1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_send", 64'(bus.out_send), 64'h0);
    check("async_rst_data", bus.out_data, 64'h0);
    check("async_rst_even_empty", 64'(bus.even_empty), 64'h1);
    check("async_rst_odd_empty", 64'(bus.odd_empty), 64'h1);
    check("async_rst_vc_err", 64'(bus.vc_err), 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 0, 0, 0, 0, 1);

    // Random traffic against the model.
    pol = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) != 0) pol = ~pol;
      ewe = ($urandom_range(1) == 1);
      owe = ($urandom_range(1) == 1);
      rdy = ($urandom_range(9) < 7);
      ewd = {$urandom, $urandom};
      owd = {$urandom, $urandom};
      ewd[63] = ($urandom_range(15) == 0);
      owd[63] = ($urandom_range(15) != 0);
      cycle(pol, ewe, ewd, owe, owd, rdy);
      if (i == 250) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
